sad_search_ctrl: RTL
====================

# sad_search_ctrl

Sequencer for block-matching motion search: given a template block and a search area in frame memory, it streams word pairs through a 4-lane SAD datapath. It accumulates one SAD per candidate position and reports the minimum-SAD candidate. It sits beside a core as a memory-mapped accelerator, with one read port into frame memory and one into template memory. Candidate positions step by one word (4 pixels) horizontally and one row vertically.

## Interface
- `AW`, 16: word-address width of both memory ports
- `Clk`  in  1: clock, all state on rising edge
- `Reset`  in  1: synchronous, active-high; returns block to IDLE
- `start`  in  1: single-cycle request; sampled only in IDLE
- `frame_base`  in  AW: word address of search-area top-left
- `frame_stride`  in  AW: words per frame row
- `tmpl_base`  in  AW: word address of template top-left; template rows are packed
- `tmpl_w`  in  4: template width in words (1..15)
- `tmpl_h`  in  6: template height in rows (1..63)
- `search_w`, `search_h`  in  8 each: number of candidate columns (words) and rows
- `f_rd`, `f_addr`  out  1, AW: frame read strobe and address
- `f_rdata`  in  32: frame data, valid the cycle after `f_rd`
- `t_rd`, `t_addr`  out  1, AW: template read strobe and address
- `t_rdata`  in  32: template data, valid the cycle after `t_rd`
- `busy`  out  1: high from the cycle after start is accepted until `done`
- `done`  out  1: one-cycle pulse; results valid from this cycle until the next accepted start
- `best_sad`  out  32: minimum SAD found
- `best_x`, `best_y`  out  8 each: candidate column (words) and row of `best_sad`

## Operation
- Configuration inputs are latched on the accepted start and ignored afterwards.
- States:
  - IDLE -> ISSUE on start.
  - ISSUE: one read pair per cycle, row-major over the template, N = tmpl_w*tmpl_h reads. -> DRAIN after the last read.
  - DRAIN: the last data is accumulated. -> CMP.
  - CMP: the candidate result is compared. -> ISSUE for the next candidate, or -> DONE after the last candidate.
  - DONE: pulses `done`. -> IDLE.
- Candidate order: cx from 0 to search_w-1 inside cy from 0 to search_h-1.
- Frame address = frame_base + (cy+r)*frame_stride + cx + c.
- Template address = tmpl_base + r*tmpl_w + c.
- Both addresses come from incremental row/column base registers; no multipliers.
- Lane arithmetic: each of the 4 byte lanes computes |a-b| on unsigned 8-bit values (0..255). The lane sum is 0..1020, zero-extended to 32 bits.
- Accumulator is 32 bits, cleared at the start of each candidate. No overflow is possible (max 1020*15*63).
- Comparison is strict less-than, so ties keep the earliest candidate in scan order.
- Results are initialised to best_sad=32'hFFFFFFFF, best_x=0, best_y=0 on an accepted start.
- Zero dimension (tmpl_w, tmpl_h, search_w or search_h = 0): no reads are issued. IDLE -> DONE directly and results keep their initialised values.
- `start` while busy is ignored.
- `Reset` mid-search aborts immediately. No further reads are issued, and no `done` pulse is produced for the aborted search.

## Timing
- Reset values: all outputs 0, except best_sad=32'hFFFFFFFF.
- `f_rd` and `t_rd` are always asserted together, in ISSUE only.
- Each candidate takes N+2 cycles (N issue cycles, 1 DRAIN, 1 CMP).
- `done` is high exactly S*(N+2)+1 cycles after the start edge, where S = search_w*search_h.
- Zero-dimension case: `done` is high 2 cycles after the start edge.
- Results update in the CMP cycle and are stable while `done` is high.

## Configuration
- `SAD_EARLY_TERM_EN` defined:
  - In ISSUE, if accumulator + incoming lane sum >= best_sad, the candidate is abandoned.
  - Remaining reads for that candidate are not issued; it goes to DRAIN then CMP with no update.
  - The Timing cycle counts become upper bounds.
- Not defined: every candidate performs all N reads, and the Timing cycle counts are exact.
- Reported results are identical either way.

## Structure
- Shared package `sad_pkg`:
  - state encoding IDLE/ISSUE/DRAIN/CMP/DONE
  - SAD_INIT = 32'hFFFFFFFF
  - width constants for tmpl_w, tmpl_h and search coordinates
- One sub-module, `sad4_lane`: combinational 4-lane unsigned |a-b| sum, 32 bit in, 32 bit out, correct for both a<b and a>b per lane.

## Test plan
- 1x1 template 0x10203040, 1x1 search, frame word 0x0F223A50 -> best_sad=29, best=(0,0), `done` 4 cycles after start.
- 2x2 template, 3x3 search, exact copy at (2,1), all other words differing -> best_sad=0, best=(2,1), `done` at 9*6+1=55 cycles.
- Two candidates tying at the minimum, at (1,0) and (0,2) -> best=(1,0).
- tmpl_h=0 -> no `f_rd`, `done` at 2 cycles, best_sad=32'hFFFFFFFF.
- Reset asserted during ISSUE, then `start` asserted 3 cycles later with new configuration -> no stale `done`, second search produces correct result.
- With `SAD_EARLY_TERM_EN`, same stimulus as the 2x2/3x3 case -> identical result and fewer total `f_rd` cycles. Without it, exactly 36 `f_rd` cycles.

Source files
------------

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state encoding and constants for the SAD search controller
package sad_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } sad_state_t;

  localparam logic [31:0] SAD_INIT = 32'hFFFF_FFFF;

  localparam int TW_W = 4;
  localparam int TH_W = 6;
  localparam int SC_W = 8;

endpackage

// File: rtl/sad4_lane.sv
// rtl/sad4_lane.sv - combinational 4-lane unsigned absolute-difference sum
module sad4_lane (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  logic [7:0] w_diff [4];
  logic [9:0] w_total;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] w_a;
    logic [7:0] w_b;
    assign w_a = i_a[8*g +: 8];
    assign w_b = i_b[8*g +: 8];
    // Subtract the smaller byte from the larger so the lane never wraps
    assign w_diff[g] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  end

  assign w_total = {2'b00, w_diff[0]} + {2'b00, w_diff[1]}
                 + {2'b00, w_diff[2]} + {2'b00, w_diff[3]};
  assign o_sum   = {22'd0, w_total};

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - block-matching SAD search sequencer; SAD_EARLY_TERM_EN enables early candidate abandon
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [AW-1:0] frame_base,
  input  logic [AW-1:0] frame_stride,
  input  logic [AW-1:0] tmpl_base,
  input  logic [3:0]    tmpl_w,
  input  logic [5:0]    tmpl_h,
  input  logic [7:0]    search_w,
  input  logic [7:0]    search_h,
  output logic          f_rd,
  output logic [AW-1:0] f_addr,
  input  logic [31:0]   f_rdata,
  output logic          t_rd,
  output logic [AW-1:0] t_addr,
  input  logic [31:0]   t_rdata,
  output logic          busy,
  output logic          done,
  output logic [31:0]   best_sad,
  output logic [7:0]    best_x,
  output logic [7:0]    best_y
);

  sad_state_t r_state;
  sad_state_t w_next_state;

  logic [TW_W-1:0] r_tw, r_c;
  logic [TH_W-1:0] r_th, r_r;
  logic [SC_W-1:0] r_sw, r_sh, r_cx, r_cy;
  logic [AW-1:0]   r_stride, r_tbase;
  logic [AW-1:0]   r_cand, r_cand_row, r_f_row, r_f_addr, r_t_addr;
  logic [31:0]     r_acc, r_best;
  logic [SC_W-1:0] r_best_x, r_best_y;
  logic            r_rd_d, r_zero_wait;

  logic [31:0]     w_lane, w_acc_next;
  logic [AW-1:0]   w_next_cand;
  logic            w_zero_dim, w_row_end, w_last_rd, w_col_end, w_last_cand, w_abandon;

  sad4_lane u_lane (
    .i_a   (f_rdata),
    .i_b   (t_rdata),
    .o_sum (w_lane)
  );

  assign w_acc_next  = r_acc + w_lane;
  assign w_zero_dim  = (tmpl_w == '0) || (tmpl_h == '0) || (search_w == '0) || (search_h == '0);
  assign w_row_end   = (r_c == r_tw - TW_W'(1));
  assign w_last_rd   = w_row_end && (r_r == r_th - TH_W'(1));
  assign w_col_end   = (r_cx == r_sw - SC_W'(1));
  assign w_last_cand = w_col_end && (r_cy == r_sh - SC_W'(1));
  // Top-left of the next candidate: one word right, or first column of the next row
  assign w_next_cand = w_col_end ? (r_cand_row + r_stride) : (r_cand + AW'(1));

`ifdef SAD_EARLY_TERM_EN
  // A partial sum already at or above the best can never win, so stop reading it
  assign w_abandon = (r_state == S_ISSUE) && r_rd_d && (w_acc_next >= r_best);
`else
  assign w_abandon = 1'b0;
`endif

  assign best_sad = r_best;
  assign best_x   = r_best_x;
  assign best_y   = r_best_y;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; the zero-dimension path holds DONE one extra cycle before pulsing
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = w_zero_dim ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_rd || w_abandon) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_CMP;
      S_CMP:   w_next_state = w_last_cand ? S_DONE : S_ISSUE;
      S_DONE:  w_next_state = r_zero_wait ? S_DONE : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: read strobes and addresses only while issuing
  always_comb begin
    f_rd   = 1'b0;
    t_rd   = 1'b0;
    f_addr = '0;
    t_addr = '0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_ISSUE: begin
        f_rd   = 1'b1;
        t_rd   = 1'b1;
        f_addr = r_f_addr;
        t_addr = r_t_addr;
        busy   = 1'b1;
      end
      S_DRAIN, S_CMP: busy = 1'b1;
      S_DONE: begin
        done = !r_zero_wait;
        busy = r_zero_wait;
      end
      default: ;
    endcase
  end

  // Datapath: config latch, incremental address walkers, accumulator and best tracking
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tw        <= '0;
      r_th        <= '0;
      r_sw        <= '0;
      r_sh        <= '0;
      r_stride    <= '0;
      r_tbase     <= '0;
      r_c         <= '0;
      r_r         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cand      <= '0;
      r_cand_row  <= '0;
      r_f_row     <= '0;
      r_f_addr    <= '0;
      r_t_addr    <= '0;
      r_acc       <= '0;
      r_best      <= SAD_INIT;
      r_best_x    <= '0;
      r_best_y    <= '0;
      r_rd_d      <= 1'b0;
      r_zero_wait <= 1'b0;
    end else begin
      r_rd_d <= (r_state == S_ISSUE);
      if (r_rd_d) r_acc <= w_acc_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_tw        <= tmpl_w;
          r_th        <= tmpl_h;
          r_sw        <= search_w;
          r_sh        <= search_h;
          r_stride    <= frame_stride;
          r_tbase     <= tmpl_base;
          r_c         <= '0;
          r_r         <= '0;
          r_cx        <= '0;
          r_cy        <= '0;
          r_cand      <= frame_base;
          r_cand_row  <= frame_base;
          r_f_row     <= frame_base;
          r_f_addr    <= frame_base;
          r_t_addr    <= tmpl_base;
          r_acc       <= '0;
          r_best      <= SAD_INIT;
          r_best_x    <= '0;
          r_best_y    <= '0;
          r_zero_wait <= w_zero_dim;
        end
        S_ISSUE: begin
          r_t_addr <= r_t_addr + AW'(1);
          if (w_row_end) begin
            r_c      <= '0;
            r_r      <= r_r + TH_W'(1);
            r_f_row  <= r_f_row + r_stride;
            r_f_addr <= r_f_row + r_stride;
          end else begin
            r_c      <= r_c + TW_W'(1);
            r_f_addr <= r_f_addr + AW'(1);
          end
        end
        S_CMP: begin
          if (r_acc < r_best) begin
            r_best   <= r_acc;
            r_best_x <= r_cx;
            r_best_y <= r_cy;
          end
          if (w_col_end) begin
            r_cx       <= '0;
            r_cy       <= r_cy + SC_W'(1);
            r_cand_row <= w_next_cand;
          end else begin
            r_cx <= r_cx + SC_W'(1);
          end
          r_cand   <= w_next_cand;
          r_f_row  <= w_next_cand;
          r_f_addr <= w_next_cand;
          r_t_addr <= r_tbase;
          r_c      <= '0;
          r_r      <= '0;
          r_acc    <= '0;
        end
        S_DONE: r_zero_wait <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
